// File: rtl/frogger_pkg.sv
// Shared lane constants for the horizontal-mover sequencer: per-lane
// periods (in base ticks), travel directions, sprite width and wrap edges.
package frogger_pkg;

  // Tables below cover lanes 0..MAX_LANES-1; NUM_LANES must not exceed this.
  localparam int MAX_LANES = 4;

  localparam logic [7:0] PERIOD_SLOW [MAX_LANES] = '{8'd2, 8'd3, 8'd4, 8'd5};
  localparam logic [7:0] PERIOD_FAST [MAX_LANES] = '{8'd1, 8'd2, 8'd2, 8'd3};

  // Bit i: 0 = lane i moves left, 1 = lane i moves right.
  localparam logic [MAX_LANES-1:0] DIR = 4'b1010;

  // 11-bit so that x + OBJ_W cannot overflow during edge compares.
  localparam logic [10:0] OBJ_W        = 11'd48;
  localparam logic [10:0] X_LEFT_EDGE  = 11'd207;
  localparam logic [10:0] X_WRAP_RIGHT = 11'd431;

  typedef enum logic {ARB_IDLE, ARB_SERVE} arb_state_e;

  // One step of lane motion, wrapping once the sprite fully leaves the field.
  function automatic logic [9:0] lane_step(input logic [9:0] x, input logic dir);
    logic [10:0] xe;
    xe = {1'b0, x};
    if (!dir) begin
      if (xe + OBJ_W < X_LEFT_EDGE) return X_WRAP_RIGHT[9:0];
      else                          return x - 10'd1;
    end else begin
      if (xe > X_WRAP_RIGHT) return 10'(X_LEFT_EDGE - OBJ_W);
      else                   return x + 10'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to the lane after the granted one.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;
  int            s;

  // Scan requests cyclically starting from the pointer.
  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    idx   = '0;
    found = 1'b0;
    s     = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      idx = PW'(s);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

  // Advance the pointer past the granted lane; hold when nothing is granted.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)      ptr <= '0;
    else if (found) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

endmodule

// File: rtl/lane_motion_ctrl.sv
// Lane motion sequencer: a prescaler produces base ticks, each lane's
// period counter raises a one-deep pending flag on expiry, and one shared
// update unit steps a single pending lane per cycle in round-robin order.
module lane_motion_ctrl
  import frogger_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int PRESCALE  = 10000
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   stage2x,
  input  logic                   pause,
  input  logic [NUM_LANES*10-1:0] lane_center,
  output logic [NUM_LANES*10-1:0] lane_x,
  output logic [NUM_LANES-1:0]   lane_moved,
  output logic                   busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]                pre;
  logic                         base_tick;
  logic [NUM_LANES-1:0][7:0]    cnt;
  logic [NUM_LANES-1:0][7:0]    period;
  logic [NUM_LANES-1:0][9:0]    x_q;
  logic [NUM_LANES-1:0]         expire;
  logic [NUM_LANES-1:0]         pending;
  logic [NUM_LANES-1:0]         pending_nxt;
  logic [NUM_LANES-1:0]         gnt;
  arb_state_e                   state;

  assign base_tick = !pause && (pre == PW'(PRESCALE - 1));
  assign lane_x    = x_q;
  assign busy      = (state == ARB_SERVE);

  // Only registered pending bits are arbitrated, so service trails expiry.
  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .req       (pending),
    .gnt       (gnt)
  );

  // Expiry uses >= so a stage switch to a shorter period fires on the next tick;
  // a new expiry on a lane being served keeps its pending bit set.
  always_comb begin
    period      = '0;
    expire      = '0;
    pending_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      period[i]      = stage2x ? PERIOD_FAST[i] : PERIOD_SLOW[i];
      expire[i]      = base_tick && (({1'b0, cnt[i]} + 9'd1) >= {1'b0, period[i]});
      pending_nxt[i] = expire[i] | (pending[i] & ~gnt[i]);
    end
  end

  // Prescaler, lane timers, pending flags, lane positions and arbiter FSM.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      pre        <= '0;
      cnt        <= '0;
      pending    <= '0;
      x_q        <= lane_center;
      lane_moved <= '0;
      state      <= ARB_IDLE;
    end else begin
      if (!pause) pre <= base_tick ? '0 : pre + PW'(1);
      for (int i = 0; i < NUM_LANES; i++) begin
        if (base_tick) cnt[i] <= expire[i] ? 8'd0 : cnt[i] + 8'd1;
        if (gnt[i])    x_q[i] <= lane_step(x_q[i], DIR[i]);
      end
      pending    <= pending_nxt;
      lane_moved <= gnt;
      case (state)
        ARB_IDLE:  if (|pending_nxt)           state <= ARB_SERVE;
        ARB_SERVE: if (pending_nxt == '0)      state <= ARB_IDLE;
        default:                               state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_motion_ctrl.sv
// Directed bench: expected lane_moved events (cycle, lane, new x) are queued
// as each scenario starts; a negedge monitor pops and compares every pulse.
// cyc counts rising edges since the last reset release (edge n -> cyc == n).
module tb_lane_motion_ctrl;

  localparam int NL = 4;

  logic            frame_clk = 1'b0;
  logic            Reset     = 1'b1;
  logic            stage2x   = 1'b0;
  logic            pause     = 1'b0;
  logic [NL*10-1:0] lane_center;
  logic [NL*10-1:0] lane_x;
  logic [NL-1:0]   lane_moved;
  logic            busy;

  int cyc;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {int cyc; int lane; int x;} ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  lane_motion_ctrl #(.NUM_LANES(NL), .PRESCALE(4)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .stage2x     (stage2x),
    .pause       (pause),
    .lane_center (lane_center),
    .lane_x      (lane_x),
    .lane_moved  (lane_moved),
    .busy        (busy)
  );

  always #5 frame_clk = ~frame_clk;

  always @(posedge frame_clk or posedge Reset)
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic logic [NL*10-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic push(input int c, input int l, input int x);
    ev_t e;
    e.cyc = c; e.lane = l; e.x = x;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 500) begin
      @(negedge frame_clk);
      guard++;
    end
    if (cyc != n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc%0d: stuck at cyc %0d", n, cyc);
    end
  endtask

  // Monitor: every lane_moved pulse must match the head of the queue.
  always @(negedge frame_clk) begin
    if (!Reset) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_moved[i]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: lane%0d cyc%0d x=%0d, required no pulse",
                     i, cyc, lane_x[10*i +: 10]);
          end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.cyc != cyc || mon_ev.lane != i || mon_ev.x != int'(lane_x[10*i +: 10])) begin
              miscompares++;
              $display("FAIL pulse: got lane%0d cyc%0d x=%0d, required lane%0d cyc%0d x=%0d",
                       i, cyc, lane_x[10*i +: 10], mon_ev.lane, mon_ev.cyc, mon_ev.x);
            end
          end
        end
      end
    end
  end

  initial begin
    // ---- Scenario A: slow table, positions chosen to hit both wrap edges ----
    lane_center = pack4(300, 431, 159, 432);
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    check("rst_lane_x", 64'(lane_x), 64'(pack4(300, 431, 159, 432)));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_moved", 64'(lane_moved), 64'd0);
    // Ticks land on edges 4,8,12,... ; lane 0 expires on tick 2 (edge 8).
    push(9, 0, 299);
    push(13, 1, 432);
    push(17, 2, 158);   // 159+48 = 207, not below the edge
    push(18, 0, 298);
    push(21, 3, 159);   // 432 > 431 -> 207-48
    push(25, 0, 297);
    push(26, 1, 159);
    push(33, 2, 431);   // 158+48 = 206 < 207 -> wrap
    push(34, 0, 296);
    Reset = 1'b0;
    wait_cyc(8);
    check("A_busy_c8", 64'(busy), 64'd1);
    wait_cyc(9);
    check("A_busy_c9", 64'(busy), 64'd0);
    wait_cyc(36);

    // ---- Scenario B: switch to fast table so all four lanes pend at once ----
    // Lane 0 is served alone first, leaving the pointer at lane 1, so the
    // burst is served 1,2,3,0; lane 0 re-expires on the edge it is served.
    lane_center = pack4(300, 300, 300, 300);
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    push(9, 0, 299);
    push(13, 1, 301);
    push(14, 2, 299);
    push(15, 3, 301);
    push(16, 0, 298);
    push(17, 0, 297);
    push(21, 1, 302);
    push(22, 2, 298);
    push(23, 0, 296);
    Reset = 1'b0;
    wait_cyc(10);
    stage2x = 1'b1;
    wait_cyc(12);
    check("B_busy_c12", 64'(busy), 64'd1);
    wait_cyc(16);
    check("B_busy_c16", 64'(busy), 64'd1);
    wait_cyc(17);
    check("B_busy_c17", 64'(busy), 64'd0);
    wait_cyc(20);
    check("B_busy_c20", 64'(busy), 64'd1);

    // ---- Scenario C: pause with lanes 0,1,2 pending; they still get served ----
    pause = 1'b1;
    wait_cyc(40);
    check("C_frozen_c40", 64'(lane_x), 64'(pack4(296, 302, 298, 301)));
    check("C_busy_c40", 64'(busy), 64'd0);
    wait_cyc(60);
    check("C_frozen_c60", 64'(lane_x), 64'(pack4(296, 302, 298, 301)));
    wait_cyc(70);
    pause = 1'b0;
    // Next tick on edge 74 makes lanes 0 and 3 pending.
    wait_cyc(74);
    check("C_busy_c74", 64'(busy), 64'd1);

    // ---- Scenario D: reset while busy drops the pending updates ----
    Reset = 1'b1;
    stage2x = 1'b0;
    repeat (2) @(negedge frame_clk);
    check("D_rst_lane_x", 64'(lane_x), 64'(pack4(300, 300, 300, 300)));
    check("D_rst_busy", 64'(busy), 64'd0);
    check("D_rst_moved", 64'(lane_moved), 64'd0);
    push(9, 0, 299);
    Reset = 1'b0;
    wait_cyc(1);
    check("D_moved_c1", 64'(lane_moved), 64'd0);
    wait_cyc(8);
    check("D_busy_c8", 64'(busy), 64'd1);
    wait_cyc(12);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
